// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the downstream mmu port.
// The arbiter uses the slave view; whatever drives requests and models mmu uses master.
interface mem_bus_arbiter_if #(
    parameter int MEM_W = 32
);
    localparam int BE_W = MEM_W / 8;

    logic             r0_req_i;
    logic [31:0]      r0_addr_i;
    logic             r0_we_i;
    logic [BE_W-1:0]  r0_be_i;
    logic [MEM_W-1:0] r0_wdata_i;
    logic             r0_gnt_o;
    logic             r0_rvalid_o;
    logic             r0_err_o;
    logic [MEM_W-1:0] r0_rdata_o;

    logic             r1_req_i;
    logic [31:0]      r1_addr_i;
    logic             r1_we_i;
    logic [BE_W-1:0]  r1_be_i;
    logic [MEM_W-1:0] r1_wdata_i;
    logic             r1_gnt_o;
    logic             r1_rvalid_o;
    logic             r1_err_o;
    logic [MEM_W-1:0] r1_rdata_o;

    logic             mem_req_o;
    logic [31:0]      mem_addr_o;
    logic             mem_we_o;
    logic [BE_W-1:0]  mem_be_o;
    logic [MEM_W-1:0] mem_wdata_o;
    logic             mem_rvalid_i;
    logic             mem_err_i;
    logic [MEM_W-1:0] mem_rdata_i;

    modport slave (
        input  r0_req_i, r0_addr_i, r0_we_i, r0_be_i, r0_wdata_i,
        output r0_gnt_o, r0_rvalid_o, r0_err_o, r0_rdata_o,
        input  r1_req_i, r1_addr_i, r1_we_i, r1_be_i, r1_wdata_i,
        output r1_gnt_o, r1_rvalid_o, r1_err_o, r1_rdata_o,
        output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        input  mem_rvalid_i, mem_err_i, mem_rdata_i
    );

    modport master (
        output r0_req_i, r0_addr_i, r0_we_i, r0_be_i, r0_wdata_i,
        input  r0_gnt_o, r0_rvalid_o, r0_err_o, r0_rdata_o,
        output r1_req_i, r1_addr_i, r1_we_i, r1_be_i, r1_wdata_i,
        input  r1_gnt_o, r1_rvalid_o, r1_err_o, r1_rdata_o,
        input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        output mem_rvalid_i, mem_err_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one mmu bus between the scalar core (port 0) and the
// vector unit (port 1); one transaction in flight, watchdog-protected completion.
module mem_bus_arbiter #(
    parameter int MEM_W   = 32,
    parameter int TIMEOUT = 256
) (
    input logic              clk,
    input logic              rst,
    mem_bus_arbiter_if.slave bus
);
    localparam int          BE_W      = MEM_W / 8;
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t           state_q, state_d;
    logic             owner_q, last_q, first_q;
    logic [15:0]      wdog_q;
    logic [31:0]      addr_q;
    logic             we_q;
    logic [BE_W-1:0]  be_q;
    logic [MEM_W-1:0] wdata_q;

    logic grant, win, rsp, timeout, err, rvalid, live;

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        win     = 1'b0;
        rsp     = 1'b0;
        timeout = 1'b0;
        err     = 1'b0;
        rvalid  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.r0_req_i || bus.r1_req_i) begin
                    grant   = 1'b1;
                    // On a tie the port that did not win last time goes first.
                    win     = (bus.r0_req_i && bus.r1_req_i) ? ~last_q : bus.r1_req_i;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                rsp     = bus.mem_rvalid_i || bus.mem_err_i;
                timeout = !rsp && (wdog_q == WDOG_LAST);
                err     = bus.mem_err_i || timeout;
                rvalid  = bus.mem_rvalid_i && !bus.mem_err_i;
                if (rsp || timeout) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            first_q <= 1'b0;
            wdog_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                owner_q <= win;
                last_q  <= win;
                first_q <= 1'b1;
                wdog_q  <= '0;
                addr_q  <= win ? bus.r1_addr_i  : bus.r0_addr_i;
                we_q    <= win ? bus.r1_we_i    : bus.r0_we_i;
                be_q    <= win ? bus.r1_be_i    : bus.r0_be_i;
                wdata_q <= win ? bus.r1_wdata_i : bus.r0_wdata_i;
            end else if (state_q == BUSY) begin
                first_q <= 1'b0;
                if (!rsp) wdog_q <= wdog_q + 16'd1;
            end
        end
    end

    // Everything is silenced while reset is held, so an abandoned transaction never completes.
    assign live = !rst;

    assign bus.r0_gnt_o    = live && grant && !win;
    assign bus.r1_gnt_o    = live && grant &&  win;
    assign bus.r0_rvalid_o = live && rvalid && !owner_q;
    assign bus.r1_rvalid_o = live && rvalid &&  owner_q;
    assign bus.r0_err_o    = live && err && !owner_q;
    assign bus.r1_err_o    = live && err &&  owner_q;
    assign bus.r0_rdata_o  = (live && rvalid && !owner_q) ? bus.mem_rdata_i : '0;
    assign bus.r1_rdata_o  = (live && rvalid &&  owner_q) ? bus.mem_rdata_i : '0;

    assign bus.mem_req_o   = live && (state_q == BUSY) && first_q;
    assign bus.mem_addr_o  = live ? addr_q  : '0;
    assign bus.mem_we_o    = live && we_q;
    assign bus.mem_be_o    = live ? be_q    : '0;
    assign bus.mem_wdata_o = live ? wdata_q : '0;
endmodule
